layer3_pool_writeback: RTL and testbench
========================================

// Module: layer3_pool_writeback
// PURPOSE
//  Downstream of the layer-3 2x2 max-pooling stage: captures its pooled 128-bit pixels (8 ch x 16b),
//  keeps only stride-2 window positions, buffers them in a small FIFO and serialises each pixel into
//  32-bit write beats to the layer-4 feature-map SRAM over a req/gnt port. Signals store completion once
//  the pooling stage reports done and every buffered pixel has been written.
// PARAMETERS
//  DATA_W      128    pooled pixel width (8 channels x 16b)
//  BUS_W       32     memory write-data width; BEATS = DATA_W/BUS_W = 4
//  FIFO_DEPTH  4      pixel buffer entries (power of 2)
//  OUT_WIDTH   13     pooled map width in pixels (row pitch)
//  BASE_ADDR   32'h0  byte address of pooled pixel (0,0), beat 0
//  DECIMATE    1      1: accept only even row AND even col; 0: accept every save_enable
// PORTS
//  clk                      in   1    clock
//  rst                      in   1    reset, asynchronous, active-low
//  save_enable              in   1    pooled pixel valid (no backpressure to producer)
//  output_row               in   16   window row of pooled pixel
//  output_col               in   16   window col of pooled pixel
//  output_data              in   128  pooled pixel, ch0 in [15:0]
//  layer3_calculation_done  in   1    one-cycle pulse: producer finished
//  mem_req                  out  1    write request
//  mem_addr                 out  32   byte address of current beat
//  mem_wdata                out  32   current beat data
//  mem_gnt                  in   1    beat accepted this cycle
//  layer3_store_done        out  1    one-cycle pulse: all pixels written
//  overflow                 out  1    sticky: a pixel was dropped (FIFO full)
// BEHAVIOUR
//  - Reset (rst=0, async): FIFO empty, FSM IDLE, mem_req=0, mem_addr=0, mem_wdata=0,
//    layer3_store_done=0, overflow=0, done-latch=0. Reset mid-burst abandons the burst; no beats resume.
//  - Capture: push = save_enable && (!DECIMATE || (!output_row[0] && !output_col[0])).
//    Entry = {output_data, prow=output_row>>DECIMATE, pcol=output_col>>DECIMATE}.
//  - Push accepted if count<FIFO_DEPTH or a pop occurs the same cycle; otherwise entry dropped,
//    overflow<=1 (held until reset). Simultaneous push+pop on empty not allowed to bypass: pop only on stored data.
//  - FSM IDLE: if FIFO non-empty -> pop head into holding reg, beat=0, go BURST (mem_req rises the cycle
//    after pop; first mem_req = 2 cycles after the capturing save_enable cycle).
//  - BURST: mem_req=1; mem_addr = BASE_ADDR + ((prow*OUT_WIDTH + pcol)*BEATS + beat)*4 (32b, wrap mod 2^32);
//    mem_wdata = hold[beat*32 +: 32] (beat 0 = ch0/ch1). addr/wdata stable while req && !gnt.
//    On gnt: beat<BEATS-1 -> beat++; beat==BEATS-1 -> if FIFO non-empty pop next and beat=0 (stay BURST,
//    back-to-back, no idle cycle) else mem_req=0, go IDLE. gnt with req=0 ignored.
//  - Done: layer3_calculation_done sets done-latch. When latch=1 && FIFO empty && FSM IDLE && no push this
//    cycle -> layer3_store_done=1 for exactly one cycle, latch cleared. Done pulse coinciding with last
//    push waits for that pixel. Done with nothing ever captured -> store_done on the following cycle.
//  - Arithmetic: prow*OUT_WIDTH computed in 32b unsigned; no saturation.
// STRUCTURE
//  - Shared package (layer3_pkg): typedef pool_pixel_t (logic[127:0]), typedef wb_entry_t
//    {pool_pixel_t data; logic[15:0] prow, pcol}, localparam BEATS, FSM enum {WB_IDLE, WB_BURST}.
//  - One sub-module: layer3_wb_fifo (sync FIFO of wb_entry_t, push/pop/full/empty/count).
//  - Top: capture filter, done latch, FSM, beat counter, address generator.
// TESTING
//  1 Single pixel: save_enable row=2 col=4 data=128'h0007_0006_..._0000, gnt always 1 -> 4 beats at
//    addr (1*13+2)*16 = 0xF0,0xF4,0xF8,0xFC, wdata 32'h0001_0000 first; then IDLE.
//  2 Decimation: stream full 26x26 window row (col 0..25) on even row -> exactly 13 pixels written;
//    odd row -> none; DECIMATE=0 -> every save_enable written.
//  3 Stall: gnt low for 5 cycles on beat 2 -> addr/wdata/req unchanged through stall, beat 3 follows gnt.
//  4 Overflow: gnt=0, push 6 consecutive even-col pixels -> 4 stored (+1 in hold), 1 dropped, overflow=1
//    sticky; release gnt -> 5 pixels written in order, back-to-back with no req gap.
//  5 Done ordering: done pulse while 3 pixels queued -> store_done exactly once, one cycle after last
//    beat's gnt; done with empty FIFO -> store_done next cycle.
//  6 Reset mid-burst at beat 1 -> all outputs 0 immediately; after release new pixel starts at beat 0.

Source files
------------

// File: rtl/layer3_pkg.sv
// Shared types and constants for the layer-3 pooled-pixel writeback path.
package layer3_pkg;

  localparam int unsigned PIXEL_W = 128;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BEATS   = PIXEL_W / WORD_W;
  localparam int unsigned BEAT_W  = $clog2(BEATS);

  typedef logic [PIXEL_W-1:0] pool_pixel_t;

  typedef struct packed {
    pool_pixel_t data;
    logic [15:0] prow;
    logic [15:0] pcol;
  } wb_entry_t;

  typedef enum logic {
    WB_IDLE,
    WB_BURST
  } wb_state_t;

  // Byte address of beat 0 of pooled pixel (prow, pcol); wraps modulo 2^32.
  function automatic logic [31:0] pixel_addr(input logic [31:0] base,
                                             input logic [31:0] width,
                                             input logic [15:0] prow,
                                             input logic [15:0] pcol);
    logic [31:0] idx;
    idx = {16'b0, prow} * width + {16'b0, pcol};
    return base + ((idx * BEATS) << 2);
  endfunction

endpackage

// File: rtl/layer3_wb_fifo.sv
// Synchronous FIFO of writeback entries; a push into a full FIFO succeeds only
// when a pop frees the head slot in the same cycle.
module layer3_wb_fifo
  import layer3_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  wb_entry_t              wr_entry,
  output wb_entry_t              rd_entry,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] FULL_COUNT = CW'(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full     = (count == FULL_COUNT);
    empty    = (count == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    rd_entry = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/layer3_pool_writeback.sv
// Captures stride-2 pooled pixels, buffers them and writes each one to the
// layer-4 feature-map SRAM as BEATS consecutive 32-bit req/gnt beats.
module layer3_pool_writeback
  import layer3_pkg::*;
#(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned BUS_W      = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OUT_WIDTH  = 13,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned DECIMATE   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              save_enable,
  input  logic [15:0]       output_row,
  input  logic [15:0]       output_col,
  input  logic [DATA_W-1:0] output_data,
  input  logic              layer3_calculation_done,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  output logic [BUS_W-1:0]  mem_wdata,
  input  logic              mem_gnt,
  output logic              layer3_store_done,
  output logic              overflow
);

  wb_state_t                   state;
  wb_entry_t                   in_entry;
  wb_entry_t                   fifo_head;
  wb_entry_t                   hold;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [BEAT_W-1:0]           beat;
  logic [BEAT_W-1:0]           next_beat;
  logic                        last_beat;
  logic                        push;
  logic                        pop;
  logic                        done_latch;
  logic                        store_fire;

  always_comb begin
    push          = save_enable &&
                    ((DECIMATE == 0) || (!output_row[0] && !output_col[0]));
    in_entry.data = output_data;
    in_entry.prow = output_row >> DECIMATE;
    in_entry.pcol = output_col >> DECIMATE;
    last_beat     = (beat == BEAT_W'(BEATS - 1));
    next_beat     = beat + 1'b1;
    // Pops only ever consume stored entries: a same-cycle push never bypasses.
    pop           = !fifo_empty &&
                    ((state == WB_IDLE) ||
                     ((state == WB_BURST) && mem_gnt && last_beat));
    store_fire    = (done_latch || layer3_calculation_done) &&
                    (fifo_count == '0) && (state == WB_IDLE) && !push;
  end

  layer3_wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_entry(in_entry),
    .rd_entry(fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= WB_IDLE;
      hold      <= '0;
      beat      <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        WB_IDLE: begin
          if (!fifo_empty) begin
            hold      <= fifo_head;
            beat      <= '0;
            mem_addr  <= pixel_addr(BASE_ADDR, 32'(OUT_WIDTH),
                                    fifo_head.prow, fifo_head.pcol);
            mem_wdata <= fifo_head.data[BUS_W-1:0];
            mem_req   <= 1'b1;
            state     <= WB_BURST;
          end
        end
        WB_BURST: begin
          if (mem_gnt) begin
            if (!last_beat) begin
              beat      <= next_beat;
              mem_addr  <= mem_addr + 32'd4;
              mem_wdata <= hold.data[next_beat*BUS_W +: BUS_W];
            end else if (!fifo_empty) begin
              // Next pixel loads directly from BURST so req never drops.
              hold      <= fifo_head;
              beat      <= '0;
              mem_addr  <= pixel_addr(BASE_ADDR, 32'(OUT_WIDTH),
                                      fifo_head.prow, fifo_head.pcol);
              mem_wdata <= fifo_head.data[BUS_W-1:0];
            end else begin
              mem_req <= 1'b0;
              state   <= WB_IDLE;
            end
          end
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_latch        <= 1'b0;
      layer3_store_done <= 1'b0;
      overflow          <= 1'b0;
    end else begin
      done_latch        <= (done_latch || layer3_calculation_done) && !store_fire;
      layer3_store_done <= store_fire;
      if (push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_layer3_pool_writeback.sv
// Randomised bench for layer3_pool_writeback: a reference queue of expected
// {addr, wdata} beats per instance is checked against every granted beat.
module tb_layer3_pool_writeback;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         save_enable = 1'b0;
  logic         save_nd = 1'b0;
  logic [15:0]  row = '0;
  logic [15:0]  col = '0;
  logic [127:0] data = '0;
  logic         calc_done = 1'b0;
  logic         gnt = 1'b0;

  logic         req0, req1, sdone0, sdone1, ovf0, ovf1;
  logic [31:0]  addr0, addr1, wdata0, wdata1;

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;
  int beats0 = 0;
  int beats1 = 0;
  int done_cnt = 0;
  int done1_cnt = 0;
  int done_cyc = 0;
  int last_acc = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  always #5 clk = ~clk;

  layer3_pool_writeback #(
    .DATA_W(128), .BUS_W(32), .FIFO_DEPTH(4), .OUT_WIDTH(13),
    .BASE_ADDR(32'h0), .DECIMATE(1)
  ) dut (
    .clk(clk), .rst(rst), .save_enable(save_enable), .output_row(row),
    .output_col(col), .output_data(data), .layer3_calculation_done(calc_done),
    .mem_req(req0), .mem_addr(addr0), .mem_wdata(wdata0), .mem_gnt(gnt),
    .layer3_store_done(sdone0), .overflow(ovf0)
  );

  layer3_pool_writeback #(
    .DATA_W(128), .BUS_W(32), .FIFO_DEPTH(4), .OUT_WIDTH(13),
    .BASE_ADDR(32'h0), .DECIMATE(0)
  ) dut_nd (
    .clk(clk), .rst(rst), .save_enable(save_nd), .output_row(row),
    .output_col(col), .output_data(data), .layer3_calculation_done(calc_done),
    .mem_req(req1), .mem_addr(addr1), .mem_wdata(wdata1), .mem_gnt(gnt),
    .layer3_store_done(sdone1), .overflow(ovf1)
  );

  // Expected beats of one pixel: pixel index = prow*13 + pcol, 16 bytes per pixel.
  task automatic model_pixel(input bit nd, input logic [15:0] r, input logic [15:0] c,
                             input logic [127:0] d);
    int unsigned pr, pc, a;
    if (!nd && ((r % 2) != 0 || (c % 2) != 0)) return;
    pr = nd ? r : r / 2;
    pc = nd ? c : c / 2;
    for (int b = 0; b < 4; b++) begin
      a = (pr * 13 + pc) * 16 + b * 4;
      if (nd) q1.push_back({a, d[b*32 +: 32]});
      else    q0.push_back({a, d[b*32 +: 32]});
    end
  endtask

  task automatic cyc();
    logic [63:0] exp;
    @(negedge clk);
    cycle++;
    if (req0 && gnt) begin
      beats0++;
      last_acc = cycle;
      n_cmp++;
      if (q0.size() == 0) begin
        n_bad++;
        $display("FAIL beat: unexpected beat addr=%h wdata=%h, required none", addr0, wdata0);
      end else begin
        exp = q0.pop_front();
        if ({addr0, wdata0} !== exp) begin
          n_bad++;
          $display("FAIL beat: addr=%h wdata=%h, required addr=%h wdata=%h",
                   addr0, wdata0, exp[63:32], exp[31:0]);
        end
      end
    end
    if (req1 && gnt) begin
      beats1++;
      n_cmp++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL beat_nd: unexpected beat addr=%h wdata=%h, required none", addr1, wdata1);
      end else begin
        exp = q1.pop_front();
        if ({addr1, wdata1} !== exp) begin
          n_bad++;
          $display("FAIL beat_nd: addr=%h wdata=%h, required addr=%h wdata=%h",
                   addr1, wdata1, exp[63:32], exp[31:0]);
        end
      end
    end
    if (sdone0) begin
      done_cnt++;
      done_cyc = cycle;
      n_cmp++;
      if (q0.size() != 0) begin
        n_bad++;
        $display("FAIL early_done: store_done with %0d beats pending, required 0", q0.size());
      end
    end
    if (sdone1) done1_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < max) begin
      cyc();
      n++;
    end
    repeat (3) cyc();
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d/%0d beats pending, required 0/0", q0.size(), q1.size());
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({req0, addr0, wdata0, sdone0, ovf0} !== '0) begin
      n_bad++;
      $display("FAIL reset: req=%b addr=%h wdata=%h done=%b ovf=%b, required all 0",
               req0, addr0, wdata0, sdone0, ovf0);
    end
    rst = 1'b1;
    cyc();
    cyc();
    n_cmp++;
    if (req0 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: req=%b, required 0", req0);
    end
  endtask

  task automatic test_single();
    gnt = 1'b1;
    row = 16'd2;
    col = 16'd4;
    data = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    model_pixel(0, row, col, data);
    save_enable = 1'b1;
    cyc();
    save_enable = 1'b0;
    n_cmp++;
    if (req0 !== 1'b0) begin
      n_bad++;
      $display("FAIL single_latency: req=%b one cycle after capture, required 0", req0);
    end
    cyc();
    n_cmp++;
    if ({req0, addr0, wdata0} !== {1'b1, 32'h0000_00F0, 32'h0001_0000}) begin
      n_bad++;
      $display("FAIL single_first: req=%b addr=%h wdata=%h, required 1 000000f0 00010000",
               req0, addr0, wdata0);
    end
    drain(20);
    n_cmp++;
    if (req0 !== 1'b0) begin
      n_bad++;
      $display("FAIL single_idle: req=%b, required 0", req0);
    end
  endtask

  task automatic test_stall();
    gnt = 1'b1;
    row = 16'd6;
    col = 16'd10;
    data = rnd128();
    model_pixel(0, row, col, data);
    save_enable = 1'b1;
    cyc();
    save_enable = 1'b0;
    repeat (3) cyc();
    n_cmp++;
    if (q0.size() != 2 || {addr0, wdata0} !== q0[0]) begin
      n_bad++;
      $display("FAIL stall_setup: addr=%h pending=%0d, required beat 2 with 2 pending",
               addr0, q0.size());
    end
    gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_cmp++;
      if (req0 !== 1'b1 || {addr0, wdata0} !== q0[0]) begin
        n_bad++;
        $display("FAIL stall_hold: req=%b addr=%h wdata=%h, required 1 %h %h",
                 req0, addr0, wdata0, q0[0][63:32], q0[0][31:0]);
      end
    end
    gnt = 1'b1;
    drain(20);
  endtask

  task automatic test_decimation();
    int b0, b1;
    gnt = 1'b1;
    b0 = beats0;
    for (int r = 4; r <= 5; r++) begin
      for (int c = 0; c < 26; c++) begin
        row = 16'(r);
        col = 16'(c);
        data = rnd128();
        model_pixel(0, row, col, data);
        save_enable = 1'b1;
        cyc();
        save_enable = 1'b0;
        cyc();
        cyc();
      end
    end
    drain(40);
    n_cmp++;
    if (beats0 - b0 != 52) begin
      n_bad++;
      $display("FAIL decim_count: %0d beats, required 52", beats0 - b0);
    end
    b1 = beats1;
    for (int c = 0; c < 6; c++) begin
      row = 16'd7;
      col = 16'(c);
      data = rnd128();
      model_pixel(1, row, col, data);
      save_nd = 1'b1;
      cyc();
      save_nd = 1'b0;
      repeat (5) cyc();
    end
    drain(40);
    n_cmp++;
    if (beats1 - b1 != 24 || ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
      n_bad++;
      $display("FAIL nodecim_count: %0d beats ovf=%b/%b, required 24 beats ovf=0/0",
               beats1 - b1, ovf0, ovf1);
    end
  endtask

  task automatic test_random();
    int w;
    for (int p = 0; p < 20; p++) begin
      w = 0;
      while ((q0.size() > 8 || $urandom_range(0, 3) != 0) && w < 200) begin
        gnt = ($urandom_range(0, 9) < 7);
        cyc();
        w++;
      end
      row = 16'($urandom_range(0, 30));
      col = 16'($urandom_range(0, 30));
      data = rnd128();
      model_pixel(0, row, col, data);
      save_enable = 1'b1;
      gnt = ($urandom_range(0, 9) < 7);
      cyc();
      save_enable = 1'b0;
    end
    gnt = 1'b1;
    drain(80);
    n_cmp++;
    if (ovf0 !== 1'b0) begin
      n_bad++;
      $display("FAIL random_ovf: overflow=%b, required 0", ovf0);
    end
  endtask

  task automatic test_done();
    int c0;
    gnt = 1'b1;
    done_cnt = 0;
    done1_cnt = 0;
    row = 16'd8;
    for (int c = 0; c < 3; c++) begin
      col = 16'(2 * c);
      data = rnd128();
      model_pixel(0, row, col, data);
      save_enable = 1'b1;
      cyc();
    end
    save_enable = 1'b0;
    calc_done = 1'b1;
    cyc();
    calc_done = 1'b0;
    drain(40);
    n_cmp++;
    if (done_cnt != 1 || done_cyc - last_acc != 2) begin
      n_bad++;
      $display("FAIL done_queued: %0d pulses, gap %0d, required 1 pulse gap 2",
               done_cnt, done_cyc - last_acc);
    end
    done_cnt = 0;
    c0 = cycle;
    calc_done = 1'b1;
    cyc();
    calc_done = 1'b0;
    repeat (4) cyc();
    n_cmp++;
    if (done_cnt != 1 || done_cyc != c0 + 2) begin
      n_bad++;
      $display("FAIL done_empty: %0d pulses at cycle %0d, required 1 at %0d",
               done_cnt, done_cyc, c0 + 2);
    end
    done_cnt = 0;
    row = 16'd10;
    col = 16'd6;
    data = rnd128();
    model_pixel(0, row, col, data);
    save_enable = 1'b1;
    calc_done = 1'b1;
    cyc();
    save_enable = 1'b0;
    calc_done = 1'b0;
    drain(20);
    n_cmp++;
    if (done_cnt != 1 || done_cyc - last_acc != 2) begin
      n_bad++;
      $display("FAIL done_with_push: %0d pulses, gap %0d, required 1 pulse gap 2",
               done_cnt, done_cyc - last_acc);
    end
    n_cmp++;
    if (done1_cnt != 3) begin
      n_bad++;
      $display("FAIL done_nd: %0d pulses, required 3", done1_cnt);
    end
  endtask

  task automatic test_overflow();
    int gaps, n;
    gnt = 1'b0;
    row = 16'd0;
    for (int c = 0; c < 6; c++) begin
      col = 16'(2 * c);
      data = rnd128();
      if (c < 5) model_pixel(0, row, col, data);
      save_enable = 1'b1;
      cyc();
    end
    save_enable = 1'b0;
    cyc();
    cyc();
    n_cmp++;
    if (ovf0 !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_set: overflow=%b, required 1", ovf0);
    end
    gnt = 1'b1;
    gaps = 0;
    n = 0;
    while (q0.size() != 0 && n < 40) begin
      if (req0 !== 1'b1) gaps++;
      cyc();
      n++;
    end
    drain(10);
    n_cmp++;
    if (gaps != 0 || ovf0 !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_drain: %0d req gaps overflow=%b, required 0 gaps overflow=1",
               gaps, ovf0);
    end
  endtask

  task automatic test_reset_mid();
    gnt = 1'b1;
    row = 16'd10;
    col = 16'd12;
    data = rnd128();
    model_pixel(0, row, col, data);
    save_enable = 1'b1;
    cyc();
    save_enable = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({req0, addr0, wdata0, sdone0, ovf0} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: req=%b addr=%h wdata=%h done=%b ovf=%b, required all 0",
               req0, addr0, wdata0, sdone0, ovf0);
    end
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
    n_cmp++;
    if (req0 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_resume: req=%b, required 0", req0);
    end
    row = 16'd2;
    col = 16'd2;
    data = rnd128();
    model_pixel(0, row, col, data);
    save_enable = 1'b1;
    cyc();
    save_enable = 1'b0;
    cyc();
    n_cmp++;
    if ({req0, addr0} !== {1'b1, 32'h0000_00E0}) begin
      n_bad++;
      $display("FAIL reset_restart: req=%b addr=%h, required 1 000000e0", req0, addr0);
    end
    drain(20);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_decimation();
    test_random();
    test_done();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
